wb_stage: RTL

- Write-back stage directly upstream of the general-purpose register file.
- Accepts one retiring instruction per handshake from execute: either an ALU result or a load.
- For loads, issues a single memory read, aligns and sign/zero-extends the returned lane, then drives the register file write port (rd_we / rd_waddr / rd_wdata) for exactly one cycle.
- Also reports misaligned and timed-out loads.

---
 rtl/wb_stage_pkg.sv | 24 ++
 rtl/wb_stage_if.sv | 39 +++
 rtl/wb_stage_load_align.sv | 32 +++
 rtl/wb_stage.sv | 135 +++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Shared encodings for the write-back stage: load sizes, FSM states and constants.
package wb_stage_pkg;

  localparam logic [1:0] LS_BYTE = 2'd0;
  localparam logic [1:0] LS_HALF = 2'd1;
  localparam logic [1:0] LS_WORD = 2'd2;
  localparam logic [1:0] LS_RSVD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int unsigned ZeroReg  = 0;
  localparam int unsigned ZeroWord = 0;
  localparam logic        Enable   = 1'b1;

  // Reserved size, odd halfword or non-word-aligned word loads are faults.
  function automatic logic ld_illegal(input logic [1:0] size, input logic [1:0] a);
    return (size == LS_RSVD) || (size == LS_HALF && a[0]) || (size == LS_WORD && a != 2'b00);
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Execute-side handshake, memory read port and register-file write port of wb_stage.
interface wb_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              I_valid;
  logic              O_ready;
  logic              I_rd_we;
  logic [REG_AW-1:0] I_rd_waddr;
  logic [DATA_W-1:0] I_alu_result;
  logic              I_is_load;
  logic [1:0]        I_ld_size;
  logic              I_ld_unsigned;
  logic              O_mem_req_valid;
  logic              I_mem_req_ready;
  logic [DATA_W-1:0] O_mem_addr;
  logic              I_mem_resp_valid;
  logic [DATA_W-1:0] I_mem_resp_data;
  logic              O_rd_we;
  logic [REG_AW-1:0] O_rd_waddr;
  logic [DATA_W-1:0] O_rd_wdata;
  logic              O_misaligned;
  logic              O_timeout;
  logic              O_busy;

  modport slave (
    input  I_valid, I_rd_we, I_rd_waddr, I_alu_result, I_is_load, I_ld_size, I_ld_unsigned,
           I_mem_req_ready, I_mem_resp_valid, I_mem_resp_data,
    output O_ready, O_mem_req_valid, O_mem_addr, O_rd_we, O_rd_waddr, O_rd_wdata,
           O_misaligned, O_timeout, O_busy
  );

  modport master (
    output I_valid, I_rd_we, I_rd_waddr, I_alu_result, I_is_load, I_ld_size, I_ld_unsigned,
           I_mem_req_ready, I_mem_resp_valid, I_mem_resp_data,
    input  O_ready, O_mem_req_valid, O_mem_addr, O_rd_we, O_rd_waddr, O_rd_wdata,
           O_misaligned, O_timeout, O_busy
  );
endinterface

// File: rtl/wb_stage_load_align.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it.
module load_align
  import wb_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word_i,
  input  logic [1:0]        addr_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  output logic [DATA_W-1:0] data_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    case (addr_i)
      2'd0:    b = word_i[7:0];
      2'd1:    b = word_i[15:8];
      2'd2:    b = word_i[23:16];
      default: b = word_i[31:24];
    endcase
    h = addr_i[1] ? word_i[31:16] : word_i[15:0];
    case (size_i)
      LS_BYTE: data_o = {{(DATA_W-8){~unsigned_i & b[7]}}, b};
      LS_HALF: data_o = {{(DATA_W-16){~unsigned_i & h[15]}}, h};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: retires ALU results in one cycle, runs loads through a
// REQ/RESP read sequence and drives a registered one-cycle register-file write.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int REG_AW       = 5,
  parameter int RESP_TIMEOUT = 255
) (
  input  logic     clk,
  input  logic     rst,
  wb_stage_if.slave bus
);

  localparam int CNT_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(RESP_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [1:0]        lo_q, size_q;
  logic              uns_q, rdwe_q;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] maddr_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              rd_we_q, rd_we_d, misal_q, misal_d, tout_q, tout_d;
  logic [REG_AW-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, ld_data;
  logic              idle, hs, illegal, tc;

  assign idle    = (state_q == ST_IDLE);
  assign hs      = bus.I_valid & idle;
  assign illegal = ld_illegal(bus.I_ld_size, bus.I_alu_result[1:0]);
  // Terminal count is the last permitted wait cycle; a response in it still wins.
  assign tc      = (RESP_TIMEOUT != 0) && (cnt_q == TO_LAST);

  load_align #(.DATA_W(DATA_W)) u_align (
    .word_i     (bus.I_mem_resp_data),
    .addr_i     (lo_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (ld_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (hs && bus.I_is_load && !illegal) state_d = ST_REQ;
      ST_REQ:  if (bus.I_mem_req_ready) state_d = ST_RESP;
      ST_RESP: if (bus.I_mem_resp_valid || tc) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.O_ready         = idle;
    bus.O_mem_req_valid = (state_q == ST_REQ);
    bus.O_busy          = !idle;
    rd_we_d = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    misal_d = 1'b0;
    tout_d  = 1'b0;
    case (state_q)
      ST_IDLE: if (hs) begin
        if (!bus.I_is_load) begin
          if (bus.I_rd_we && bus.I_rd_waddr != REG_AW'(ZeroReg)) begin
            rd_we_d = Enable;
            waddr_d = bus.I_rd_waddr;
            wdata_d = bus.I_alu_result;
          end
        end else if (illegal) begin
          misal_d = Enable;
        end
      end
      ST_RESP: if (bus.I_mem_resp_valid) begin
        if (rdwe_q && rd_q != REG_AW'(ZeroReg)) begin
          rd_we_d = Enable;
          waddr_d = rd_q;
          wdata_d = ld_data;
        end
      end else if (tc) begin
        tout_d = Enable;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_we_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= DATA_W'(ZeroWord);
      misal_q <= 1'b0;
      tout_q  <= 1'b0;
      lo_q    <= 2'b00;
      size_q  <= LS_BYTE;
      uns_q   <= 1'b0;
      rdwe_q  <= 1'b0;
      rd_q    <= '0;
      maddr_q <= DATA_W'(ZeroWord);
      cnt_q   <= '0;
    end else begin
      rd_we_q <= rd_we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      misal_q <= misal_d;
      tout_q  <= tout_d;
      if (hs && bus.I_is_load) begin
        lo_q    <= bus.I_alu_result[1:0];
        size_q  <= bus.I_ld_size;
        uns_q   <= bus.I_ld_unsigned;
        rdwe_q  <= bus.I_rd_we;
        rd_q    <= bus.I_rd_waddr;
        maddr_q <= {bus.I_alu_result[DATA_W-1:2], 2'b00};
      end
      if (state_q == ST_REQ)
        cnt_q <= '0;
      else if (state_q == ST_RESP && !bus.I_mem_resp_valid)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.O_mem_addr   = maddr_q;
  assign bus.O_rd_we      = rd_we_q;
  assign bus.O_rd_waddr   = waddr_q;
  assign bus.O_rd_wdata   = wdata_q;
  assign bus.O_misaligned = misal_q;
  assign bus.O_timeout    = tout_q;

endmodule
